// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the Mini-MIPS multi-cycle sequencer: state codes,
// special opcodes, PC / write-back source selects and the Decode control bundle.
package mips_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_MULW   = 3'd4;
    localparam state_t ST_MEM    = 3'd5;
    localparam state_t ST_WB     = 3'd6;
    localparam state_t ST_HALT   = 3'd7;

    localparam logic [5:0] OP_FINISH = 6'h3F;
    localparam logic [5:0] FN_JR     = 6'h08;
    localparam logic [4:0] ALU_MUL   = 5'b01101;

    typedef enum logic [1:0] {
        PC_SEL_PLUS4  = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JUMP   = 2'd2,
        PC_SEL_RS     = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_LINK = 2'd2
    } wb_sel_e;

    // Subset of the Decode outputs the sequencer actually steers on.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       jump;
        logic       jump_reg;
        logic       link;
        logic [4:0] alu_ctrl;
    } ctrl_t;

    function automatic logic is_busy_state(input state_t s);
        return (s != ST_IDLE) && (s != ST_HALT);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Instruction/data memory handshake between the sequencer (master) and the
// memory side (slave).
interface mips_multicycle_ctrl_if;

    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_ack,
        output dmem_ack
    );

endinterface

// File: rtl/mips_branch_eval.sv
// Combinational branch resolution from the Decode branch strobes and the
// ALU compare flags of the rs - rt subtraction.
module mips_branch_eval (
    input  logic branch_eq,
    input  logic branch_ne,
    input  logic branch_gt,
    input  logic branch_gte,
    input  logic branch_lt,
    input  logic branch_lte,
    input  logic branch_gtu,
    input  logic branch_ltu,
    input  logic alu_zero,
    input  logic alu_lt,
    input  logic alu_ltu,
    output logic any_branch,
    output logic taken
);

    assign any_branch = branch_eq | branch_ne | branch_gt  | branch_gte |
                        branch_lt | branch_lte | branch_gtu | branch_ltu;

    assign taken = (branch_eq  &  alu_zero)                 |
                   (branch_ne  & ~alu_zero)                 |
                   (branch_gt  & ~alu_lt  & ~alu_zero)      |
                   (branch_gte & ~alu_lt)                   |
                   (branch_lt  &  alu_lt)                   |
                   (branch_lte & (alu_lt | alu_zero))       |
                   (branch_gtu & ~alu_ltu & ~alu_zero)      |
                   (branch_ltu &  alu_ltu);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer for the Mini-MIPS core: walks each instruction through
// FETCH/DECODE/EXEC[/MULW|MEM][/WB] and pulses the datapath enables.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  mem_to_reg,
    input  logic                  reg_dst,
    input  logic                  alu_src,
    input  logic                  jump,
    input  logic                  jump_reg,
    input  logic                  link,
    input  logic                  branch_eq,
    input  logic                  branch_ne,
    input  logic                  branch_gt,
    input  logic                  branch_gte,
    input  logic                  branch_lt,
    input  logic                  branch_lte,
    input  logic                  branch_gtu,
    input  logic                  branch_ltu,
    input  logic [4:0]            alu_ctrl,
    input  logic                  alu_zero,
    input  logic                  alu_lt,
    input  logic                  alu_ltu,
    mips_multicycle_ctrl_if.master mem,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic [1:0]            pc_sel,
    output logic                  rf_we,
    output logic [1:0]            wb_sel,
    output logic                  hilo_we,
    output logic                  halted,
    output logic                  busy,
    output logic [CNT_W-1:0]      retired
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

    ctrl_t   ctrl;
    logic    any_branch;
    logic    br_taken;
    logic    jr_hit;
    logic    unused_decode;

    state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic    ir_we_d, pc_we_d, rf_we_d, hilo_we_d, retire;
    pc_sel_e pc_sel_d;
    wb_sel_e wb_sel_d;

    logic    ir_we_q, pc_we_q, rf_we_q, hilo_we_q;
    pc_sel_e pc_sel_q;
    wb_sel_e wb_sel_q;
    logic    imem_req_q, dmem_req_q, dmem_we_q, halted_q, busy_q;
    logic [CNT_W-1:0] retired_q;

    assign ctrl = '{
        reg_write:  reg_write,
        mem_read:   mem_read,
        mem_write:  mem_write,
        mem_to_reg: mem_to_reg,
        jump:       jump,
        jump_reg:   jump_reg,
        link:       link,
        alu_ctrl:   alu_ctrl
    };

    // Register-destination and ALU-operand selects are datapath-only concerns.
    assign unused_decode = ^{reg_dst, alu_src};

    assign jr_hit = ctrl.jump_reg | ((opcode == 6'h00) && (funct == FN_JR));

    mips_branch_eval u_branch_eval (
        .branch_eq  (branch_eq),
        .branch_ne  (branch_ne),
        .branch_gt  (branch_gt),
        .branch_gte (branch_gte),
        .branch_lt  (branch_lt),
        .branch_lte (branch_lte),
        .branch_gtu (branch_gtu),
        .branch_ltu (branch_ltu),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .alu_ltu    (alu_ltu),
        .any_branch (any_branch),
        .taken      (br_taken)
    );

    // Enables are decided on the transition and registered, so each pulse
    // lands in the first cycle of the state that follows the decision.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ir_we_d   = 1'b0;
        pc_we_d   = 1'b0;
        pc_sel_d  = PC_SEL_PLUS4;
        rf_we_d   = 1'b0;
        wb_sel_d  = WB_SEL_ALU;
        hilo_we_d = 1'b0;
        retire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (mem.imem_ack) begin
                    ir_we_d = 1'b1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = (opcode == OP_FINISH) ? ST_HALT : ST_EXEC;
            end

            ST_EXEC: begin
                if (any_branch) begin
                    pc_we_d  = 1'b1;
                    pc_sel_d = br_taken ? PC_SEL_BRANCH : PC_SEL_PLUS4;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else if (jr_hit) begin
                    // Decode raises reg_write for all opcode-0 words; jr must not write.
                    pc_we_d  = 1'b1;
                    pc_sel_d = PC_SEL_RS;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else if (ctrl.jump) begin
                    pc_we_d  = 1'b1;
                    pc_sel_d = PC_SEL_JUMP;
                    rf_we_d  = ctrl.link;
                    wb_sel_d = ctrl.link ? WB_SEL_LINK : WB_SEL_ALU;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end else if (ctrl.alu_ctrl == ALU_MUL) begin
                    cnt_d   = MUL_LOAD;
                    state_d = ST_MULW;
                end else if (ctrl.mem_read || ctrl.mem_write) begin
                    state_d = ST_MEM;
                end else begin
                    rf_we_d  = ctrl.reg_write;
                    wb_sel_d = ctrl.mem_to_reg ? WB_SEL_MEM : WB_SEL_ALU;
                    pc_we_d  = 1'b1;
                    retire   = 1'b1;
                    state_d  = ST_WB;
                end
            end

            ST_MULW: begin
                if (cnt_q == 4'd0) begin
                    hilo_we_d = 1'b1;
                    pc_we_d   = 1'b1;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_MEM: begin
                if (mem.dmem_ack) begin
                    if (ctrl.mem_write) begin
                        pc_we_d = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        rf_we_d  = ctrl.reg_write;
                        wb_sel_d = ctrl.mem_to_reg ? WB_SEL_MEM : WB_SEL_ALU;
                        pc_we_d  = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_WB;
                    end
                end
            end

            ST_WB: begin
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            ir_we_q    <= 1'b0;
            pc_we_q    <= 1'b0;
            pc_sel_q   <= PC_SEL_PLUS4;
            rf_we_q    <= 1'b0;
            wb_sel_q   <= WB_SEL_ALU;
            hilo_we_q  <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b0;
            busy_q     <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ir_we_q    <= ir_we_d;
            pc_we_q    <= pc_we_d;
            pc_sel_q   <= pc_sel_d;
            rf_we_q    <= rf_we_d;
            wb_sel_q   <= wb_sel_d;
            hilo_we_q  <= hilo_we_d;
            // Requests follow the state they belong to and are held while in it.
            imem_req_q <= (state_d == ST_FETCH);
            dmem_req_q <= (state_d == ST_MEM);
            dmem_we_q  <= (state_d == ST_MEM) && ctrl.mem_write;
            halted_q   <= (state_d == ST_HALT);
            busy_q     <= is_busy_state(state_d);
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign mem.imem_req = imem_req_q;
    assign mem.dmem_req = dmem_req_q;
    assign mem.dmem_we  = dmem_we_q;
    assign ir_we        = ir_we_q;
    assign pc_we        = pc_we_q;
    assign pc_sel       = pc_sel_q;
    assign rf_we        = rf_we_q;
    assign wb_sel       = wb_sel_q;
    assign hilo_we      = hilo_we_q;
    assign halted       = halted_q;
    assign busy         = busy_q;
    assign retired      = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: each instruction's enable trace is
// scored against per-class expectations derived from the sequencing rules.
module tb_mips_multicycle_ctrl;

    localparam int ML = 4;

    localparam int C_ALU = 0, C_NOP = 1, C_LOAD = 2, C_STORE = 3, C_BRANCH = 4,
                   C_J = 5, C_JAL = 6, C_JR = 7, C_MUL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  opcode, funct;
    logic        reg_write, mem_read, mem_write, mem_to_reg, reg_dst, alu_src;
    logic        jump, jump_reg, link;
    logic [7:0]  br;
    logic [4:0]  alu_ctrl;
    logic        alu_zero, alu_lt, alu_ltu;
    logic        ir_we, pc_we, rf_we, hilo_we, halted, busy;
    logic [1:0]  pc_sel, wb_sel;
    logic [31:0] retired;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_retired = 0;

    mips_multicycle_ctrl_if mem_if ();

    mips_multicycle_ctrl #(.MUL_LATENCY(ML), .CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .opcode     (opcode),
        .funct      (funct),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .alu_src    (alu_src),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .link       (link),
        .branch_eq  (br[0]),
        .branch_ne  (br[1]),
        .branch_gt  (br[2]),
        .branch_gte (br[3]),
        .branch_lt  (br[4]),
        .branch_lte (br[5]),
        .branch_gtu (br[6]),
        .branch_ltu (br[7]),
        .alu_ctrl   (alu_ctrl),
        .alu_zero   (alu_zero),
        .alu_lt     (alu_lt),
        .alu_ltu    (alu_ltu),
        .mem        (mem_if.master),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .hilo_we    (hilo_we),
        .halted     (halted),
        .busy       (busy),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Reference branch semantics: signed/unsigned comparisons of rs vs rt.
    function automatic bit model_taken(input int k, input bit z, input bit lt, input bit ltu);
        case (k)
            0: return z;               // rs == rt
            1: return !z;              // rs != rt
            2: return !(lt || z);      // rs >  rt
            3: return !lt;             // rs >= rt
            4: return lt;              // rs <  rt
            5: return lt || z;         // rs <= rt
            6: return !(ltu || z);     // rs >u rt
            default: return ltu;       // rs <u rt
        endcase
    endfunction

    function automatic int model_len(input int cls, input int d);
        case (cls)
            C_ALU, C_NOP:               return 4;
            C_LOAD:                     return 5 + d;
            C_STORE:                    return 4 + d;
            C_MUL:                      return 3 + ML;
            default:                    return 3;
        endcase
    endfunction

    task automatic clear_decode();
        opcode = 6'h00; funct = 6'h00; reg_write = 0; mem_read = 0; mem_write = 0;
        mem_to_reg = 0; reg_dst = 0; alu_src = 0; jump = 0; jump_reg = 0; link = 0;
        br = 8'h00; alu_ctrl = 5'b00000;
    endtask

    task automatic set_decode(input int cls, input int k);
        clear_decode();
        case (cls)
            C_ALU:    begin funct = 6'h20 | 6'($urandom_range(0, 7)); reg_write = 1; reg_dst = 1;
                            alu_ctrl = 5'($urandom_range(0, 12)); end
            C_NOP:    begin opcode = 6'($urandom_range(6'h30, 6'h3E)); funct = 6'($urandom_range(0, 63)); end
            C_LOAD:   begin opcode = 6'h23; mem_read = 1; reg_write = 1; mem_to_reg = 1; alu_src = 1; end
            C_STORE:  begin opcode = 6'h2B; mem_write = 1; alu_src = 1; end
            C_BRANCH: begin opcode = 6'h04; br[k] = 1'b1; alu_ctrl = 5'b00110; end
            C_J:      begin opcode = 6'h02; jump = 1; end
            C_JAL:    begin opcode = 6'h03; jump = 1; link = 1; reg_write = 1; end
            C_JR:     begin funct = 6'h08; jump_reg = 1; reg_write = 1; end
            default:  begin funct = 6'h18; alu_ctrl = 5'b01101; reg_write = 1; end
        endcase
    endtask

    // Entered at a negedge while the DUT sits in FETCH; returns at the negedge
    // of the next FETCH entry.
    task automatic run_instr(input int cls, input int k, input bit z, input bit lt,
                             input bit ltu, input int fwait, input int dwait);
        int len = 0, pcw = 0, rfw = 0, hilo = 0, mcyc = 0, wecyc = 0, irc = 0, busy_bad = 0;
        logic [1:0] pcs = 2'd0, wbs = 2'd0;
        logic jal_same = 1'b0;
        int exp_sel, exp_rf, exp_wb, exp_mem;
        set_decode(cls, k);
        alu_zero = z; alu_lt = lt; alu_ltu = ltu;
        check("fetch_req", 32'(mem_if.imem_req), 32'd1);
        repeat (fwait) @(negedge clk);
        mem_if.imem_ack = 1'b1;
        for (int c = 1; c <= 64 && len == 0; c++) begin
            @(negedge clk);
            mem_if.imem_ack = 1'b0;
            if (c == 1) check("ir_we_c1", 32'(ir_we), 32'd1);
            if (mem_if.dmem_req) begin
                mcyc++;
                if (mem_if.dmem_we) wecyc++;
                mem_if.dmem_ack = (mcyc == dwait + 1);
            end else begin
                mem_if.dmem_ack = 1'b0;
            end
            if (pc_we) begin pcw++; pcs = pc_sel; end
            if (rf_we) begin rfw++; wbs = wb_sel; jal_same = pc_we; end
            if (hilo_we) hilo++;
            if (ir_we) irc++;
            if (mem_if.imem_req) len = c;
            else if (!busy) busy_bad++;
        end
        mem_if.dmem_ack = 1'b0;

        exp_sel = (cls == C_BRANCH) ? (model_taken(k, z, lt, ltu) ? 1 : 0) :
                  (cls == C_J || cls == C_JAL) ? 2 : (cls == C_JR) ? 3 : 0;
        exp_rf  = (cls == C_ALU || cls == C_LOAD || cls == C_JAL) ? 1 : 0;
        exp_wb  = (cls == C_LOAD) ? 1 : (cls == C_JAL) ? 2 : 0;
        exp_mem = (cls == C_LOAD || cls == C_STORE) ? dwait + 1 : 0;
        exp_retired++;

        check($sformatf("len cls%0d", cls), len, model_len(cls, dwait));
        check($sformatf("pc_we_cnt cls%0d", cls), pcw, 1);
        check($sformatf("pc_sel cls%0d k%0d zlu%0d%0d%0d", cls, k, z, lt, ltu), 32'(pcs), exp_sel);
        check($sformatf("rf_we_cnt cls%0d", cls), rfw, exp_rf);
        if (exp_rf != 0) check($sformatf("wb_sel cls%0d", cls), 32'(wbs), exp_wb);
        if (cls == C_JAL) check("jal_same_cycle", 32'(jal_same), 32'd1);
        check($sformatf("hilo_cnt cls%0d", cls), hilo, (cls == C_MUL) ? 1 : 0);
        check($sformatf("dmem_cycles cls%0d", cls), mcyc, exp_mem);
        check($sformatf("dmem_we_cycles cls%0d", cls), wecyc, (cls == C_STORE) ? exp_mem : 0);
        check("ir_we_cnt", irc, 1);
        check("busy_in_instr", busy_bad, 0);
        check("retired", retired, exp_retired);
    endtask

    task automatic do_start();
        int n = 0;
        @(negedge clk);
        check("idle_not_busy", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!mem_if.imem_req && n < 8) begin @(negedge clk); n++; end
        check("start_fetch", 32'(mem_if.imem_req), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
    endtask

    initial begin
        int n;
        clear_decode();
        alu_zero = 0; alu_lt = 0; alu_ltu = 0;
        mem_if.imem_ack = 1'b0;
        mem_if.dmem_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outs", 32'({mem_if.imem_req, mem_if.dmem_req, mem_if.dmem_we, ir_we, pc_we,
                                 pc_sel, rf_we, wb_sel, hilo_we, halted, busy}), 32'd0);
        check("reset_retired", retired, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_holds", 32'(mem_if.imem_req), 32'd0);

        do_start();

        // Directed: immediate-ack ALU op, slow load, jal, jr, mul
        run_instr(C_ALU, 0, 0, 0, 0, 0, 0);
        run_instr(C_LOAD, 0, 0, 0, 0, 0, 3);
        run_instr(C_JAL, 0, 0, 0, 0, 0, 0);
        run_instr(C_JR, 0, 0, 0, 0, 1, 0);
        run_instr(C_MUL, 0, 0, 0, 0, 0, 0);
        run_instr(C_NOP, 0, 0, 0, 0, 0, 0);
        run_instr(C_STORE, 0, 0, 0, 0, 0, 2);

        // Branch sweep: every strobe against every flag combination
        for (int k = 0; k < 8; k++)
            for (int f = 0; f < 8; f++)
                run_instr(C_BRANCH, k, f[0], f[1], f[2], 0, 0);

        // Random mix
        for (int i = 0; i < 80; i++)
            run_instr($urandom_range(0, 8), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 3));

        // FINISH: sticky halt, start ignored, counter frozen
        clear_decode();
        opcode = 6'h3F;
        mem_if.imem_ack = 1'b1;
        @(negedge clk);
        mem_if.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("halted", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 20; i++) begin
            start = 1'b1; @(negedge clk);
            start = 1'b0; @(negedge clk);
        end
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_no_fetch", 32'(mem_if.imem_req), 32'd0);
        check("halt_retired", retired, exp_retired);

        // Reset leaves HALT; then abort a load stuck in MEM
        rst_n = 1'b0;
        #1;
        check("rst_clears_halt", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_retired = 0;
        do_start();
        set_decode(C_LOAD, 0);
        mem_if.imem_ack = 1'b1;
        n = 0;
        @(negedge clk);
        mem_if.imem_ack = 1'b0;
        while (!mem_if.dmem_req && n < 10) begin @(negedge clk); n++; end
        @(negedge clk);
        check("mid_mem_req", 32'(mem_if.dmem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_dmem_req", 32'(mem_if.dmem_req), 32'd0);
        check("abort_idle", 32'({busy, halted, mem_if.imem_req, rf_we, pc_we}), 32'd0);
        check("abort_retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_stays_idle", 32'(mem_if.imem_req), 32'd0);
        do_start();
        run_instr(C_ALU, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
